bus_datapath_seq: RTL and testbench

- Parametrised successor to the single-bus CPU datapath: a register file of NREGS x DATA_W, plus Y, Z_HI/Z_LO, HI and LO registers, a shared internal bus and an ALU.
- Adds an internal micro-sequencer, so one start pulse runs a complete three-phase register-register operation: Y<=Rb, then Z<=ALU(Y,Rc), then writeback.
- Completion is signalled by a start/busy/done handshake.
- Sits between the future control unit and the register and ALU resources, and replaces per-cycle external enable/out strobes.

---
 rtl/bus_datapath_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_bus_datapath_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq
// Register-file datapath with a shared internal bus, an ALU, and a small
// micro-sequencer. One start pulse runs a three-phase register-register
// operation:
//   RB: Y <= R[rb]
//   RC: {Z_HI,Z_LO} <= ALU(op, Y, R[rc])
//   WB: write back to R[ra], or to HI/LO for MUL. Update z_flag and pulse done.
//
// Ports:
//   clk      - clock. All state updates on the rising edge.
//   clr      - asynchronous active-low reset.
//   start    - operation request. Sampled only while idle.
//   op       - 5-bit operation code, captured together with start.
//   ra/rb/rc - destination / source-1 / source-2 register indices.
//   ld_en    - external load strobe. Honoured only while not busy.
//   ld_addr  - index of the register to load.
//   ld_data  - value to load.
//   rd_addr  - debug read index.
//   rd_data  - combinational R[rd_addr]. Reads 0 for R0 when R0_ZERO=1.
//   busy     - an operation is in progress (states RB, RC, WB).
//   done     - one-cycle pulse after writeback.
//   err      - one-cycle pulse, together with done, for an illegal op.
//   z_flag   - zero flag of the last completed legal operation.
//   hi_out   - HI register contents.
//   lo_out   - LO register contents.
module bus_datapath_seq #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [4:0]               op,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    input  logic [$clog2(NREGS)-1:0] rc,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     z_flag,
    output logic [DATA_W-1:0]        hi_out,
    output logic [DATA_W-1:0]        lo_out
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(DATA_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RB   = 2'd1;
    localparam logic [1:0] RC   = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_SHR  = 5'd6;
    localparam logic [4:0] OP_SHRA = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_MFHI = 5'd9;
    localparam logic [4:0] OP_MFLO = 5'd10;

    logic [1:0]        state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [AW-1:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [DATA_W-1:0] y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              z_flag_q, z_flag_d, done_q, done_d, err_q, err_d;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [AW-1:0]         bus_sel;
    logic [DATA_W-1:0]     bus;
    logic [DATA_W-1:0]     alu_hi, alu_lo;
    logic [SW-1:0]         shamt;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, mul_prod;
    logic                  illegal;

    // The bus carries rb during RB and rc during RC. R0_ZERO masks R0 here too.
    assign bus_sel = (state_q == RB) ? rb_q : rc_q;
    assign bus     = ((R0_ZERO != 0) && (bus_sel == '0)) ? '0 : rf_q[bus_sel];
    assign shamt   = bus[SW-1:0];

    // Both operands are sign-extended to full product width, so the truncated
    // product is the exact signed 2*DATA_W result.
    assign mul_a    = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    assign mul_b    = {{DATA_W{bus[DATA_W-1]}}, bus};
    assign mul_prod = mul_a * mul_b;

    assign illegal = (op_q > OP_MFLO);

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (op_q)
            OP_ADD:  alu_lo = y_q + bus;
            OP_SUB:  alu_lo = y_q - bus;
            OP_AND:  alu_lo = y_q & bus;
            OP_OR:   alu_lo = y_q | bus;
            OP_XOR:  alu_lo = y_q ^ bus;
            OP_SHL:  alu_lo = y_q << shamt;
            OP_SHR:  alu_lo = y_q >> shamt;
            OP_SHRA: alu_lo = $unsigned($signed(y_q) >>> shamt);
            OP_MUL:  {alu_hi, alu_lo} = mul_prod;
            OP_MFHI: alu_lo = hi_q;
            OP_MFLO: alu_lo = lo_q;
            default: begin
                alu_hi = '0;
                alu_lo = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        y_d      = y_q;
        zhi_d    = zhi_q;
        zlo_d    = zlo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        z_flag_d = z_flag_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = ld_addr;
        wr_data  = ld_data;
        case (state_q)
            IDLE: begin
                // An external load can share this cycle with start. It commits
                // on the same edge, before RB reads the file.
                wr_en = ld_en;
                if (start) begin
                    op_d    = op;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                    state_d = RB;
                end
            end
            RB: begin
                y_d     = bus;
                state_d = RC;
            end
            RC: begin
                zhi_d   = alu_hi;
                zlo_d   = alu_lo;
                state_d = WB;
            end
            default: begin
                done_d  = 1'b1;
                err_d   = illegal;
                state_d = IDLE;
                if (!illegal) begin
                    if (op_q == OP_MUL) begin
                        hi_d     = zhi_q;
                        lo_d     = zlo_q;
                        z_flag_d = (zhi_q == '0) && (zlo_q == '0);
                    end else begin
                        wr_en    = 1'b1;
                        wr_addr  = ra_q;
                        wr_data  = zlo_q;
                        z_flag_d = (zlo_q == '0);
                    end
                end
            end
        endcase
        // Writes to R0 are dropped entirely when R0 is hardwired to zero.
        if ((R0_ZERO != 0) && (wr_addr == '0)) begin
            wr_en = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            assign rf_d[gi] = (wr_en && (wr_addr == AW'(gi))) ? wr_data : rf_q[gi];

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    rf_q[gi] <= '0;
                end else begin
                    rf_q[gi] <= rf_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            y_q      <= '0;
            zhi_q    <= '0;
            zlo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            z_flag_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            y_q      <= y_d;
            zhi_q    <= zhi_d;
            zlo_q    <= zlo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            z_flag_q <= z_flag_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rd_data = ((R0_ZERO != 0) && (rd_addr == '0)) ? '0 : rf_q[rd_addr];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign z_flag  = z_flag_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed testbench for bus_datapath_seq. Two instances share all inputs.
// u_dut uses R0_ZERO=0 and u_dut_z uses R0_ZERO=1.
module tb_bus_datapath_seq;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [3:0]  ra = '0, rb = '0, rc = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data, hi_out, lo_out;
    logic        busy, done, err, z_flag;
    logic [31:0] rd_data_z, hi_out_z, lo_out_z;
    logic        busy_z, done_z, err_z, z_flag_z;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    bus_datapath_seq #(.DATA_W(32), .NREGS(16), .R0_ZERO(0)) u_dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err), .z_flag(z_flag),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    bus_datapath_seq #(.DATA_W(32), .NREGS(16), .R0_ZERO(1)) u_dut_z (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .busy(busy_z), .done(done_z), .err(err_z),
        .z_flag(z_flag_z), .hi_out(hi_out_z), .lo_out(lo_out_z)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [3:0] a);
        rd_addr = a;
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Issue one operation. Return the number of ticks until done is seen (bounded).
    task automatic run_op(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, output int n);
        start = 1'b1;
        op = o;
        ra = a;
        rb = b;
        rc = c;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        n = 1;
        while (!done && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            peek(4'(i));
            checks++;
            if (rd_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd[%0d] got %h exp 0", i, rd_data);
            end
        end
        checks++;
        if ({busy, done, err, z_flag} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {busy, done, err, z_flag});
        end
        checks++;
        if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo got %h/%h exp 0/0", hi_out, lo_out);
        end
    endtask

    task automatic test_add;
        load(4'd1, 32'hFFFF_FFFF);
        load(4'd2, 32'h0000_0002);
        start = 1'b1;
        op = 5'd0;
        ra = 4'd3;
        rb = 4'd1;
        rc = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL add_busy_c%0d got busy=%b done=%b exp 1/0", i, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_done got done=%b busy=%b exp 1/0", done, busy);
        end
        peek(4'd3);
        checks++;
        if (rd_data !== 32'h0000_0001 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL add_result got %h z=%b exp 00000001 z=0", rd_data, z_flag);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse got %b exp 0", done);
        end
    endtask

    task automatic test_sub_shra;
        load(4'd4, 32'd5);
        load(4'd5, 32'd5);
        run_op(5'd1, 4'd6, 4'd4, 4'd5, cyc);
        peek(4'd6);
        checks++;
        if (cyc !== 4 || rd_data !== 32'h0 || z_flag !== 1'b1) begin
            errors++;
            $display("FAIL sub got cyc=%0d %h z=%b exp 4 00000000 z=1", cyc, rd_data, z_flag);
        end
        load(4'd7, 32'h8000_0000);
        load(4'd8, 32'h0000_0024);
        run_op(5'd7, 4'd9, 4'd7, 4'd8, cyc);
        peek(4'd9);
        checks++;
        if (rd_data !== 32'hF800_0000 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL shra got %h z=%b exp f8000000 z=0", rd_data, z_flag);
        end
        run_op(5'd4, 4'd11, 4'd4, 4'd7, cyc);
        peek(4'd11);
        checks++;
        if (rd_data !== 32'h8000_0005) begin
            errors++;
            $display("FAIL xor got %h exp 80000005", rd_data);
        end
        run_op(5'd6, 4'd12, 4'd7, 4'd8, cyc);
        peek(4'd12);
        checks++;
        if (rd_data !== 32'h0800_0000) begin
            errors++;
            $display("FAIL shr got %h exp 08000000", rd_data);
        end
    endtask

    task automatic test_mul_mfhi;
        load(4'd1, 32'hFFFF_FFFE);
        load(4'd2, 32'd3);
        run_op(5'd8, 4'd13, 4'd1, 4'd2, cyc);
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL mul got %h_%h z=%b exp ffffffff_fffffffa z=0", hi_out, lo_out, z_flag);
        end
        peek(4'd13);
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL mul_no_gpr got %h exp 0", rd_data);
        end
        run_op(5'd9, 4'd10, 4'd1, 4'd2, cyc);
        peek(4'd10);
        checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mfhi got %h exp ffffffff", rd_data);
        end
        run_op(5'd10, 4'd14, 4'd1, 4'd2, cyc);
        peek(4'd14);
        checks++;
        if (rd_data !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mflo got %h exp fffffffa", rd_data);
        end
    endtask

    task automatic test_back_to_back;
        // OR R3 = R1|R2 = fffffffe|3. Stray starts during RB and WB must be ignored.
        start = 1'b1;
        op = 5'd3;
        ra = 4'd3;
        rb = 4'd1;
        rc = 4'd2;
        tick();
        op = 5'd0;
        ra = 4'd5;
        ld_en = 1'b1;
        ld_addr = 4'd15;
        ld_data = 32'h1234;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        tick();
        start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_done got done=%b busy=%b exp 1/0", done, busy);
        end
        peek(4'd3);
        checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL hs_or got %h exp ffffffff", rd_data);
        end
        peek(4'd5);
        checks++;
        if (rd_data !== 32'd5) begin
            errors++;
            $display("FAIL hs_ignored_start got %h exp 00000005", rd_data);
        end
        peek(4'd15);
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL hs_ld_busy got %h exp 0", rd_data);
        end
        // A start in the done cycle is accepted: SUB R5 = fffffffe - 3.
        op = 5'd1;
        ra = 4'd5;
        rb = 4'd1;
        rc = 4'd2;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b exp 1/0", busy, done);
        end
        cyc = 1;
        while (!done && cyc < 12) begin
            tick();
            cyc++;
        end
        peek(4'd5);
        checks++;
        if (cyc !== 4 || rd_data !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL b2b_sub got cyc=%0d %h exp 4 fffffffb", cyc, rd_data);
        end
        // Illegal op: done and err pulse with no state change.
        run_op(5'b11111, 4'd1, 4'd2, 4'd3, cyc);
        checks++;
        if (cyc !== 4 || err !== 1'b1 || z_flag !== 1'b0) begin
            errors++;
            $display("FAIL illegal got cyc=%0d err=%b z=%b exp 4 1 0", cyc, err, z_flag);
        end
        peek(4'd1);
        checks++;
        if (rd_data !== 32'hFFFF_FFFE || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL illegal_nowrite got %h %h %h exp fffffffe ffffffff fffffffa",
                     rd_data, hi_out, lo_out);
        end
        tick();
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse got err=%b done=%b exp 0/0", err, done);
        end
    endtask

    task automatic test_load_start;
        ld_en = 1'b1;
        ld_addr = 4'd2;
        ld_data = 32'd9;
        run_op(5'd0, 4'd4, 4'd1, 4'd2, cyc);
        peek(4'd4);
        checks++;
        if (rd_data !== 32'h0000_0007) begin
            errors++;
            $display("FAIL load_start got %h exp 00000007", rd_data);
        end
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        op = 5'd0;
        ra = 4'd15;
        rb = 4'd1;
        rc = 4'd2;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got busy=%b done=%b exp 0/0", busy, done);
        end
        tick();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_nodone c%0d got done=%b busy=%b exp 0/0", i, done, busy);
            end
        end
        peek(4'd15);
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_r15 got %h exp 0", rd_data);
        end
        peek(4'd1);
        checks++;
        if (rd_data !== 32'h0 || hi_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_clear got %h %h exp 0 0", rd_data, hi_out);
        end
    endtask

    task automatic test_r0_zero;
        load(4'd0, 32'h55);
        peek(4'd0);
        checks++;
        if (rd_data !== 32'h55 || rd_data_z !== 32'h0) begin
            errors++;
            $display("FAIL r0_load got %h/%h exp 00000055/00000000", rd_data, rd_data_z);
        end
        load(4'd1, 32'd7);
        load(4'd2, 32'd8);
        run_op(5'd1, 4'd0, 4'd1, 4'd1, cyc);
        checks++;
        if (done_z !== 1'b1 || z_flag_z !== 1'b1) begin
            errors++;
            $display("FAIL r0_sub got done=%b z=%b exp 1/1", done_z, z_flag_z);
        end
        run_op(5'd0, 4'd0, 4'd1, 4'd2, cyc);
        peek(4'd0);
        checks++;
        if (rd_data !== 32'h0F || rd_data_z !== 32'h0 || z_flag_z !== 1'b0 || done_z !== 1'b1) begin
            errors++;
            $display("FAIL r0_write got %h/%h z=%b d=%b exp 0000000f/00000000 z=0 d=1",
                     rd_data, rd_data_z, z_flag_z, done_z);
        end
        run_op(5'd0, 4'd3, 4'd0, 4'd1, cyc);
        peek(4'd3);
        checks++;
        if (rd_data !== 32'h16 || rd_data_z !== 32'h7) begin
            errors++;
            $display("FAIL r0_source got %h/%h exp 00000016/00000007", rd_data, rd_data_z);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_shra();
        test_mul_mfhi();
        test_back_to_back();
        test_load_start();
        test_reset_mid();
        test_r0_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
